// File: rtl/fetch_bp_unit_if.sv
// fetch_bp_unit_if: EX-feedback / fetch-output bundle for fetch_bp_unit.
//   slave  modport : the fetch unit (consumes EX feedback, produces PC and prediction)
//   master modport : the pipeline side (produces EX feedback, consumes PC and prediction)
//   ex_*           : resolved branch/jump/trap information from the EX stage
//   flush_o        : mispredict, kill IF/ID
//   pred_*_o       : zero-cycle prediction for pc_o
//   pc_o, pc_p4_o  : current fetch PC and PC+4 (modulo 2^XLEN)
interface fetch_bp_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            ex_valid_i;
    logic [XLEN-1:0] ex_pc_i;
    logic            ex_pred_taken_i;
    logic [XLEN-1:0] ex_pred_target_i;
    logic            ex_is_br_i;
    logic            ex_is_call_i;
    logic            ex_is_ret_i;
    logic            ex_br_taken_i;
    logic [XLEN-1:0] ex_br_target_i;
    logic            ex_csr_taken_i;
    logic [XLEN-1:0] ex_csr_target_i;
    logic            flush_o;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_p4_o;

    modport slave (
        input  ex_valid_i, ex_pc_i, ex_pred_taken_i, ex_pred_target_i, ex_is_br_i,
               ex_is_call_i, ex_is_ret_i, ex_br_taken_i, ex_br_target_i,
               ex_csr_taken_i, ex_csr_target_i,
        output flush_o, pred_taken_o, pred_target_o, pc_o, pc_p4_o
    );

    modport master (
        output ex_valid_i, ex_pc_i, ex_pred_taken_i, ex_pred_target_i, ex_is_br_i,
               ex_is_call_i, ex_is_ret_i, ex_br_taken_i, ex_br_target_i,
               ex_csr_taken_i, ex_csr_target_i,
        input  flush_o, pred_taken_o, pred_target_o, pc_o, pc_p4_o
    );
endinterface

// File: rtl/fetch_bp_unit.sv
// fetch_bp_unit: fetch-stage PC generator with a direct-mapped BTB (2-bit counters,
// tag match) and an optional non-speculative return address stack.
//   clk, rst : clock, asynchronous active-high reset
//   en       : fetch enable; 0 stalls the PC unless a flush redirects it
//   bp       : fetch_bp_unit_if.slave (EX feedback in; flush, prediction, PC out)
// Build option: define FETCH_RAS_EN to include the return address stack; without it
// returns are predicted through the BTB counter/target path only.
// flush_o and the prediction are combinational (zero-cycle lookup on pc_o).
module fetch_bp_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     BTB_ENTRIES = 64,
    parameter int unsigned     RAS_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    fetch_bp_unit_if.slave bp
);
    localparam int unsigned IDXW = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = XLEN - IDXW - 2;

    typedef struct packed {
        logic            valid;
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] target;
        logic [1:0]      ctr;
`ifdef FETCH_RAS_EN
        logic            is_ret;
`endif
    } btb_entry_t;

    logic [XLEN-1:0] pc_q, pc_d;
    btb_entry_t      btb_q [BTB_ENTRIES];
    btb_entry_t      btb_d [BTB_ENTRIES];

    btb_entry_t      lk_ent_c, ex_ent_c, ex_upd_c;
    logic            lk_hit_c, ex_hit_c;
    logic            pred_taken_c, flush_c;
    logic [XLEN-1:0] pred_target_c, pc_p4_c, ex_pc_p4_c, ex_next_c, ex_pred_next_c;

`ifdef FETCH_RAS_EN
    localparam int unsigned RASW = $clog2(RAS_DEPTH);
    localparam int unsigned CNTW = RASW + 1;

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic [RASW-1:0] ras_sp_q, ras_sp_d;
    logic [CNTW-1:0] ras_cnt_q, ras_cnt_d;
`else
    logic unused_ras_c;
    assign unused_ras_c = ^{bp.ex_is_call_i, bp.ex_is_ret_i, 32'(RAS_DEPTH)};
`endif

    // Zero-cycle BTB/RAS lookup on the current fetch PC
    always_comb begin
        lk_ent_c      = btb_q[pc_q[IDXW+1:2]];
        lk_hit_c      = lk_ent_c.valid && (lk_ent_c.tag == pc_q[XLEN-1:IDXW+2]);
        pred_taken_c  = 1'b0;
        pred_target_c = '0;
`ifdef FETCH_RAS_EN
        if (lk_hit_c && lk_ent_c.is_ret && (ras_cnt_q != '0)) begin
            pred_taken_c  = 1'b1;
            pred_target_c = ras_q[ras_sp_q];
        end else
`endif
        if (lk_hit_c && lk_ent_c.ctr[1]) begin
            pred_taken_c  = 1'b1;
            pred_target_c = lk_ent_c.target;
        end
    end

    // EX resolution, mispredict detection and next fetch PC
    always_comb begin
        pc_p4_c        = pc_q + XLEN'(4);
        ex_pc_p4_c     = bp.ex_pc_i + XLEN'(4);
        ex_next_c      = bp.ex_csr_taken_i ? bp.ex_csr_target_i :
                         bp.ex_br_taken_i  ? bp.ex_br_target_i  : ex_pc_p4_c;
        ex_pred_next_c = bp.ex_pred_taken_i ? bp.ex_pred_target_i : ex_pc_p4_c;
        // Feedback is meaningless while reset is held
        flush_c        = !rst && bp.ex_valid_i && (ex_next_c != ex_pred_next_c);
        pc_d           = pc_q;
        if (flush_c) begin
            pc_d = ex_next_c;
        end else if (en) begin
            pc_d = pred_taken_c ? pred_target_c : pc_p4_c;
        end
    end

    // BTB training from resolved branches; trap/mret redirects leave it alone
    always_comb begin
        btb_d    = btb_q;
        ex_ent_c = btb_q[bp.ex_pc_i[IDXW+1:2]];
        ex_hit_c = ex_ent_c.valid && (ex_ent_c.tag == bp.ex_pc_i[XLEN-1:IDXW+2]);
        ex_upd_c = ex_ent_c;
        if (bp.ex_valid_i && bp.ex_is_br_i && !bp.ex_csr_taken_i) begin
            if (ex_hit_c) begin
                if (bp.ex_br_taken_i) begin
                    if (ex_ent_c.ctr != 2'b11) ex_upd_c.ctr = ex_ent_c.ctr + 2'd1;
                    ex_upd_c.target = bp.ex_br_target_i;
`ifdef FETCH_RAS_EN
                    ex_upd_c.is_ret = bp.ex_is_ret_i;
`endif
                end else if (ex_ent_c.ctr != 2'b00) begin
                    ex_upd_c.ctr = ex_ent_c.ctr - 2'd1;
                end
                btb_d[bp.ex_pc_i[IDXW+1:2]] = ex_upd_c;
            end else if (bp.ex_br_taken_i) begin
                ex_upd_c        = '0;
                ex_upd_c.valid  = 1'b1;
                ex_upd_c.tag    = bp.ex_pc_i[XLEN-1:IDXW+2];
                ex_upd_c.target = bp.ex_br_target_i;
                ex_upd_c.ctr    = 2'b10;
`ifdef FETCH_RAS_EN
                ex_upd_c.is_ret = bp.ex_is_ret_i;
`endif
                btb_d[bp.ex_pc_i[IDXW+1:2]] = ex_upd_c;
            end
        end
    end

`ifdef FETCH_RAS_EN
    // Non-speculative RAS: circular buffer, sp points at the top entry
    always_comb begin
        ras_d     = ras_q;
        ras_sp_d  = ras_sp_q;
        ras_cnt_d = ras_cnt_q;
        if (bp.ex_valid_i && !bp.ex_csr_taken_i) begin
            if (bp.ex_is_call_i && bp.ex_is_ret_i) begin
                ras_d[ras_sp_q] = ex_pc_p4_c;
                if (ras_cnt_q == '0) ras_cnt_d = CNTW'(1);
            end else if (bp.ex_is_call_i) begin
                ras_sp_d        = ras_sp_q + RASW'(1);
                ras_d[ras_sp_d] = ex_pc_p4_c;
                if (ras_cnt_q != CNTW'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + CNTW'(1);
            end else if (bp.ex_is_ret_i && (ras_cnt_q != '0)) begin
                ras_sp_d  = ras_sp_q - RASW'(1);
                ras_cnt_d = ras_cnt_q - CNTW'(1);
            end
        end
    end
`endif

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < int'(BTB_ENTRIES); i++) btb_q[i] <= '0;
`ifdef FETCH_RAS_EN
            for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
            ras_sp_q  <= '0;
            ras_cnt_q <= '0;
`endif
        end else begin
            pc_q  <= pc_d;
            btb_q <= btb_d;
`ifdef FETCH_RAS_EN
            ras_q     <= ras_d;
            ras_sp_q  <= ras_sp_d;
            ras_cnt_q <= ras_cnt_d;
`endif
        end
    end

    assign bp.flush_o       = flush_c;
    assign bp.pred_taken_o  = pred_taken_c;
    assign bp.pred_target_o = pred_target_c;
    assign bp.pc_o          = pc_q;
    assign bp.pc_p4_o       = pc_p4_c;
endmodule

// File: tb/tb_fetch_bp_unit.sv
// tb_fetch_bp_unit: directed self-checking bench for fetch_bp_unit.
// Inputs change 1ns after posedge; outputs are checked 1ns after that.
module tb_fetch_bp_unit;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    logic en;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_bp_unit_if #(.XLEN(XLEN)) bp ();

    fetch_bp_unit #(
        .XLEN(XLEN), .RESET_PC(32'h0000_0000), .BTB_ENTRIES(64), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .bp(bp)
    );

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                            input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [XLEN-1:0] pc,
                            input logic pt, input logic [XLEN-1:0] ptgt,
                            input logic is_br, input logic is_call, input logic is_ret,
                            input logic tk, input logic [XLEN-1:0] tgt,
                            input logic csr, input logic [XLEN-1:0] csr_tgt);
        bp.ex_valid_i       = v;
        bp.ex_pc_i          = pc;
        bp.ex_pred_taken_i  = pt;
        bp.ex_pred_target_i = ptgt;
        bp.ex_is_br_i       = is_br;
        bp.ex_is_call_i     = is_call;
        bp.ex_is_ret_i      = is_ret;
        bp.ex_br_taken_i    = tk;
        bp.ex_br_target_i   = tgt;
        bp.ex_csr_taken_i   = csr;
        bp.ex_csr_target_i  = csr_tgt;
    endtask

    task automatic clear_ex();
        drive_ex(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    // Trap-style redirect of the fetch PC; never touches BTB or RAS
    task automatic redirect(input logic [XLEN-1:0] tgt);
        drive_ex(1'b1, 32'h0000_0F00, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, tgt);
        #1;
        check_eq("redir_flush", XLEN'(bp.flush_o), 32'h1);
        tick();
        clear_ex();
        #1;
        check_eq("redir_pc", bp.pc_o, tgt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        clear_ex();
        #1;
        check_eq("rst_pc", bp.pc_o, 32'h0);
        check_eq("rst_flush", XLEN'(bp.flush_o), 32'h0);
        check_eq("rst_pred", XLEN'(bp.pred_taken_o), 32'h0);
        check_eq("rst_tgt", bp.pred_target_o, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Sequential fetch
        en = 1'b1;
        #1;
        check_eq("seq_pc0", bp.pc_o, 32'h0);
        tick(); check_eq("seq_pc4", bp.pc_o, 32'h4);
        tick(); check_eq("seq_pc8", bp.pc_o, 32'h8);
        tick(); check_eq("seq_pcC", bp.pc_o, 32'hC);
        check_eq("seq_flush", XLEN'(bp.flush_o), 32'h0);
        check_eq("seq_pred", XLEN'(bp.pred_taken_o), 32'h0);

        // Taken branch mispredicted as not taken, then predicted on refetch
        drive_ex(1'b1, 32'h10, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, '0);
        #1;
        check_eq("br_flush", XLEN'(bp.flush_o), 32'h1);
        tick();
        clear_ex();
        #1;
        check_eq("br_pc", bp.pc_o, 32'h40);
        redirect(32'h10);
        check_eq("br_pred", XLEN'(bp.pred_taken_o), 32'h1);
        check_eq("br_ptgt", bp.pred_target_o, 32'h40);
        tick();
        check_eq("br_follow", bp.pc_o, 32'h40);
        en = 1'b0;

        // Counter: 2->3 on taken, then two not-taken -> 1 (not taken)
        drive_ex(1'b1, 32'h10, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, '0);
        #1;
        check_eq("ctr_tk_noflush", XLEN'(bp.flush_o), 32'h0);
        tick();
        drive_ex(1'b1, 32'h10, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 1'b0, '0);
        #1;
        check_eq("ctr_nt1_flush", XLEN'(bp.flush_o), 32'h1);
        tick();
        clear_ex();
        #1;
        check_eq("ctr_nt1_pc", bp.pc_o, 32'h14);
        redirect(32'h10);
        check_eq("ctr2_pred", XLEN'(bp.pred_taken_o), 32'h1);
        drive_ex(1'b1, 32'h10, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 1'b0, '0);
        #1;
        check_eq("ctr_nt2_flush", XLEN'(bp.flush_o), 32'h1);
        check_eq("same_cyc_old", XLEN'(bp.pred_taken_o), 32'h1);
        tick();
        clear_ex();
        redirect(32'h10);
        check_eq("ctr1_pred", XLEN'(bp.pred_taken_o), 32'h0);
        check_eq("ctr1_tgt", bp.pred_target_o, 32'h0);

        // CSR redirect beats a taken branch and does not train the BTB
        drive_ex(1'b1, 32'h80, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h100);
        #1;
        check_eq("csr_flush", XLEN'(bp.flush_o), 32'h1);
        tick();
        clear_ex();
        #1;
        check_eq("csr_pc", bp.pc_o, 32'h100);
        redirect(32'h80);
        check_eq("csr_no_btb", XLEN'(bp.pred_taken_o), 32'h0);

        // Stall holds the PC; a flush overrides the stall
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_hold", bp.pc_o, 32'h80);
        end
        drive_ex(1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        check_eq("stall_flush", XLEN'(bp.flush_o), 32'h1);
        tick();
        clear_ex();
        #1;
        check_eq("stall_flush_pc", bp.pc_o, 32'h304);
        check_eq("pc_p4", bp.pc_p4_o, 32'h308);

        // PC+4 wraps
        redirect(32'hFFFF_FFFC);
        check_eq("p4_wrap", bp.pc_p4_o, 32'h0);
        en = 1'b1;
        tick();
        check_eq("pc_wrap", bp.pc_o, 32'h0);
        en = 1'b0;

        // Reset mid-operation clears BTB and ignores live feedback
        drive_ex(1'b1, 32'h20, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h60, 1'b0, '0);
        tick();
        clear_ex();
        redirect(32'h20);
        check_eq("pre_rst_pred", bp.pred_target_o, 32'h60);
        drive_ex(1'b1, 32'h300, 1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 1'b1, 32'h700, 1'b0, '0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_pc", bp.pc_o, 32'h0);
        check_eq("mid_rst_flush", XLEN'(bp.flush_o), 32'h0);
        check_eq("mid_rst_pred", XLEN'(bp.pred_taken_o), 32'h0);
        tick();
        check_eq("mid_rst_hold", bp.pc_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        clear_ex();
        tick();
        redirect(32'h20);
        check_eq("post_rst_btb", XLEN'(bp.pred_taken_o), 32'h0);

`ifdef FETCH_RAS_EN
        begin
            logic [XLEN-1:0] pops [4];
            pops = '{32'h34, 32'h24, 32'h14, 32'h900};
            // Return entry with an empty RAS uses the counter path
            drive_ex(1'b1, 32'h204, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h900, 1'b0, '0);
            tick();
            clear_ex();
            redirect(32'h204);
            check_eq("ret_empty_pred", XLEN'(bp.pred_taken_o), 32'h1);
            check_eq("ret_empty_tgt", bp.pred_target_o, 32'h900);
            for (int i = 0; i < 5; i++) begin
                drive_ex(1'b1, XLEN'(i * 16), 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
                tick();
                clear_ex();
            end
            #1;
            check_eq("ras_top", bp.pred_target_o, 32'h44);
            for (int i = 0; i < 4; i++) begin
                drive_ex(1'b1, 32'h204, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
                tick();
                clear_ex();
                #1;
                check_eq("ras_pop", bp.pred_target_o, pops[i]);
            end
            drive_ex(1'b1, 32'h204, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
            tick();
            clear_ex();
            #1;
            check_eq("ras_empty_pop", bp.pred_target_o, 32'h900);
            drive_ex(1'b1, 32'h60, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
            tick();
            clear_ex();
            #1;
            check_eq("ras_call_ret", bp.pred_target_o, 32'h64);
            drive_ex(1'b1, 32'h204, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
            tick();
            clear_ex();
            #1;
            check_eq("ras_cr_pop", bp.pred_target_o, 32'h900);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_bp_unit.md
Name: fetch_bp_unit

Overview:
Parametrised next-generation fetch-stage PC generator and branch predictor. Holds the fetch PC and a direct-mapped BTB with 2-bit saturating counters and tag match. Optionally holds a return address stack. Resolves EX-stage feedback into a flush/redirect and supplies pc_o and the prediction to IF/ID. Replaces the fixed-width fetch block.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
BTB_ENTRIES, 64, BTB depth; power of two, >=2; IDXW = log2(BTB_ENTRIES)
RAS_DEPTH, 4, return address stack entries; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
en  in  1  fetch enable; 0 = stall (PC holds unless flush)
ex_valid_i  in  1  EX slot holds a real instruction
ex_pc_i  in  XLEN  PC of EX instruction
ex_pred_taken_i  in  1  prediction that accompanied EX instruction
ex_pred_target_i  in  XLEN  predicted target that accompanied EX instruction
ex_is_br_i  in  1  EX instruction is branch/jump
ex_is_call_i  in  1  EX instruction is a call (jal/jalr, rd=x1/x5)
ex_is_ret_i  in  1  EX instruction is a return (jalr rs1=x1/x5, rd=x0)
ex_br_taken_i  in  1  resolved taken
ex_br_target_i  in  XLEN  resolved target
ex_csr_taken_i  in  1  trap/mret redirect
ex_csr_target_i  in  XLEN  trap/mret target
flush_o  out  1  mispredict; kill IF/ID
pred_taken_o  out  1  prediction for pc_o
pred_target_o  out  XLEN  predicted target, valid when pred_taken_o
pc_o  out  XLEN  current fetch PC
pc_p4_o  out  XLEN  pc_o + 4, wraps modulo 2^XLEN

Behaviour:
- Reset (async, rst=1): pc_o=RESET_PC; all BTB valid bits 0; RAS count 0; flush_o=0, pred_taken_o=0, pred_target_o=0.
- ex_next = ex_csr_taken_i ? ex_csr_target_i : ex_br_taken_i ? ex_br_target_i : ex_pc_i+4. CSR has priority.
- flush_o = ex_valid_i & (ex_next != (ex_pred_taken_i ? ex_pred_target_i : ex_pc_i+4)). Combinational, same cycle.
- PC update at posedge: flush_o -> pc<=ex_next, regardless of en. Else if en -> pc<=pred_taken_o ? pred_target_o : pc_p4_o. Else hold.
- BTB entry fields: valid, tag = pc[XLEN-1:IDXW+2], target, ctr[1:0], is_ret.
- Index = pc[IDXW+1:2].
- Lookup is combinational on pc_o; 0-cycle prediction. Hit = valid & tag match.
- Prediction: hit & is_ret & RAS non-empty -> taken, target = RAS top. Else hit & ctr[1] -> taken, target = stored target. Else not taken, pred_target_o=0.
- BTB update at posedge when ex_valid_i & ex_is_br_i. CSR redirects never update the BTB.
  - Hit: ctr saturating +1 if taken, -1 if not taken (bounds 0..3). Target and is_ret rewritten when taken.
  - Miss and taken: allocate/overwrite with ctr=2'b10, valid=1, is_ret=ex_is_ret_i.
  - Miss and not taken: no write.
- Same-cycle lookup and update of the same index: lookup sees the old contents (write visible next cycle).
- RAS updates are non-speculative, at posedge when ex_valid_i and not ex_csr_taken_i.
  - Call: push ex_pc_i+4.
  - Ret: pop.
  - Call and ret together: top replaced by ex_pc_i+4; count unchanged, or becomes 1 if it was 0.
  - Full push: circular overwrite of the oldest entry; count stays RAS_DEPTH.
  - Empty pop: no-op; count stays 0.
- Reset mid-operation: all state returns to reset values immediately; in-flight EX feedback is ignored until rst deasserts.

Optional Feature:
FETCH_RAS_EN
- Defined: RAS present as above.
- Undefined: no RAS storage or logic; the is_ret field is not stored. Returns predict via the BTB ctr/target path only. RAS_DEPTH is ignored.
- The port list is identical in both builds.

Test Plan:
- Reset then en=1 with no EX activity -> pc_o: 0x0, 0x4, 0x8, 0xC; flush_o=0; pred_taken_o=0.
- Taken branch at 0x10 to 0x40 resolved in EX (pred_taken=0) -> flush_o=1 that cycle, next pc_o=0x40. Next fetch of 0x10 -> pred_taken_o=1, pred_target_o=0x40.
- Entry at ctr=2'b11, then two not-taken resolutions -> ctr=2'b01 and prediction becomes not taken. The first not-taken resolution (pred_taken=1) flushes to ex_pc+4.
- ex_csr_taken_i=1 (target 0x100) and ex_br_taken_i=1 (target 0x40) in the same cycle, pred target 0x40 -> flush_o=1, pc_o=0x100, BTB and RAS unchanged.
- en=0 for 3 cycles with no flush -> pc_o holds. en=0 with flush -> pc_o takes ex_next.
- [FETCH_RAS_EN] 5 calls from 0x0,0x10,0x20,0x30,0x40 with RAS_DEPTH=4, then 5 rets -> pops give 0x44,0x34,0x24,0x14, then the empty pop leaves count 0. A ret entry hit with an empty RAS falls back to the ctr path.
